prog_loader: RTL and testbench
==============================

# prog_loader

Front-end entry stage upstream of the processor core. Debounces the two board buttons, captures the 8-bit switch word on each user-button press, and either appends it to program memory (LOAD mode) or hands it to the core as an immediate instruction (IMMEDIATE mode). Issues a one-cycle run request on a run-button press and tracks the core's run/halt handshake.

## Interface
Parameters:
- ADDR_W, 4, program-memory address width; capacity 2**ADDR_W instructions
- DEBOUNCE_CYCLES, 2, consecutive stable samples required to change a debounced button level (≥1)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous, active-high reset
- sw  in  8  instruction word from switches
- btn  in  2  btn[0] = user (enter), btn[1] = run; raw, active-high
- mem_we  out  1  program-memory write strobe, one cycle per accepted entry
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  write data
- prog_len  out  ADDR_W+1  number of instructions stored
- full  out  1  prog_len == 2**ADDR_W
- run_start  out  1  one-cycle pulse: core begins executing from address 0
- running  out  1  core executing
- cpu_done  in  1  core halted (single-cycle or level; sampled only in RUNNING)
- imm_valid  out  1  immediate instruction pending
- imm_instr  out  8  immediate instruction
- imm_ready  in  1  core accepts immediate instruction

## Operation
- States: LOAD, RUNNING, IMMEDIATE. Reset → LOAD.
- LOAD, user press: if !full, mem_we=1, mem_addr=prog_len[ADDR_W-1:0], mem_wdata=sw (captured in press cycle); prog_len increments the same edge. If full: press dropped, no write.
- LOAD, run press: if prog_len≠0, pulse run_start, → RUNNING. If prog_len==0: ignored.
- RUNNING: running=1; all button presses dropped; cpu_done=1 → IMMEDIATE, running=0 next cycle.
- IMMEDIATE, user press with imm_valid=0: imm_instr←sw, imm_valid←1. Held stable until imm_valid&imm_ready cycle; imm_valid clears the following edge. Presses while imm_valid=1 dropped.
- IMMEDIATE, run press: re-run stored program (run_start pulse → RUNNING), only if imm_valid=0; otherwise dropped.
- Same-cycle user and run presses: run wins, user dropped.
- Program contents and prog_len retained across runs; only clr empties the program.
- Debounce per button: counter counts cycles where sample ≠ debounced level; resets to 0 on any sample equal to debounced level; at DEBOUNCE_CYCLES the level flips. Press = rising edge of debounced level. Releases produce nothing.

## Timing
- Reset values: mem_we 0, mem_addr 0, mem_wdata 0, prog_len 0, full 0, run_start 0, running 0, imm_valid 0, imm_instr 0; debounced levels 0, counters 0.
- clr mid-operation: immediate return to reset values; an in-flight write or immediate is lost.
- Latency (no synchronizer): button sampled high at edge E → debounced high at edge E+DEBOUNCE_CYCLES-1 → mem_we / run_start / imm_valid registered high at the next edge. With DEBOUNCE_CYCLES=2 a 2-cycle press yields a single action 2 edges after first sample.
- mem_we and run_start never exceed one cycle per press.
- cpu_done → running low: 1 cycle.

## Configuration
- PROG_LOADER_SYNC_EN defined: sw and btn pass through 2-flop synchronizers before debounce/capture; all button-to-action latencies +2 cycles; sw captured from synchronized copy.
- Undefined: inputs used directly (bench-friendly, assumes synchronous stimulus).

## Structure
- Shared package: state enum (LOAD, RUNNING, IMMEDIATE), button index constants (BTN_USER=0, BTN_RUN=1), shared 8-bit instruction width constant.
- One sub-module: btn_debounce (parameter DEBOUNCE_CYCLES; clk, clr, raw in; level, press out), instantiated twice.

## Test plan
- Reset then user press with sw=8'h01 → one mem_we, addr 0, data 8'h01; prog_len=1.
- 17 user presses with ADDR_W=4 → writes to addrs 0..15, full=1 after 16th, 17th produces no mem_we.
- Run press with prog_len=0 → no run_start; after one entry, run press → single run_start, running=1 until cpu_done, then IMMEDIATE.
- IMMEDIATE: sw=8'h40, user press → imm_valid=1, imm_instr=8'h40; hold imm_ready=0 5 cycles and press again with sw=8'h50 → imm_instr stays 8'h40; imm_ready=1 → imm_valid 0 next cycle.
- User and run debounced same cycle in LOAD → run_start only, no mem_we; 1-cycle glitch on btn[0] with DEBOUNCE_CYCLES=2 → no action; clr asserted during RUNNING → all outputs reset, state LOAD.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the prog_loader entry stage:
// controller states, button indices and the instruction width.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    RUNNING   = 2'd1,
    IMMEDIATE = 2'd2
  } state_e;

  localparam int BTN_USER = 0;
  localparam int BTN_RUN  = 1;
  localparam int INSTR_W  = 8;

endpackage

// File: rtl/prog_loader_btn_debounce.sv
// Per-button debouncer: the level flips after DEBOUNCE_CYCLES consecutive
// samples disagree with it, and press pulses for one cycle on a rising flip.
module btn_debounce
  import prog_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             press_r;

  // Disagreement counter, debounced level and registered rising-edge pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      press_r <= 1'b0;
      if (raw == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        cnt_r   <= '0;
        level_r <= raw;
        press_r <= raw;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/prog_loader.sv
// Program loader front end: debounced buttons drive LOAD/RUNNING/IMMEDIATE.
// Define PROG_LOADER_SYNC_EN to add 2-flop synchronizers on sw and btn.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W          = 4,
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [INSTR_W-1:0] sw,
  input  logic [1:0]         btn,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic [ADDR_W:0]    prog_len,
  output logic               full,
  output logic               run_start,
  output logic               running,
  input  logic               cpu_done,
  output logic               imm_valid,
  output logic [INSTR_W-1:0] imm_instr,
  input  logic               imm_ready
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W + 1)'(1'b1);

  logic [INSTR_W-1:0] sw_s;
  logic [1:0]         btn_s;

`ifdef PROG_LOADER_SYNC_EN
  logic [INSTR_W-1:0] sw_meta_r;
  logic [INSTR_W-1:0] sw_sync_r;
  logic [1:0]         btn_meta_r;
  logic [1:0]         btn_sync_r;

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sw_meta_r  <= '0;
      sw_sync_r  <= '0;
      btn_meta_r <= 2'b00;
      btn_sync_r <= 2'b00;
    end else begin
      sw_meta_r  <= sw;
      sw_sync_r  <= sw_meta_r;
      btn_meta_r <= btn;
      btn_sync_r <= btn_meta_r;
    end
  end

  assign sw_s  = sw_sync_r;
  assign btn_s = btn_sync_r;
`else
  assign sw_s  = sw;
  assign btn_s = btn;
`endif

  logic user_level_s;
  logic run_level_s;
  logic user_press_s;
  logic run_press_s;
  logic [1:0] unused_levels_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_user_db (
    .clk   (clk),
    .clr   (clr),
    .raw   (btn_s[BTN_USER]),
    .level (user_level_s),
    .press (user_press_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk   (clk),
    .clr   (clr),
    .raw   (btn_s[BTN_RUN]),
    .level (run_level_s),
    .press (run_press_s)
  );

  assign unused_levels_s = {run_level_s, user_level_s};

  state_e             state_r;
  state_e             next_state_s;
  logic               mem_we_r,    mem_we_s;
  logic [ADDR_W-1:0]  mem_addr_r,  mem_addr_s;
  logic [INSTR_W-1:0] mem_wdata_r, mem_wdata_s;
  logic [ADDR_W:0]    prog_len_r,  prog_len_s;
  logic               full_r;
  logic               run_start_r, run_start_s;
  logic               running_r;
  logic               imm_valid_r, imm_valid_s;
  logic [INSTR_W-1:0] imm_instr_r, imm_instr_s;

  // Controller state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= LOAD;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and next-output decode; run beats user on a same-cycle press.
  always_comb begin
    next_state_s = state_r;
    mem_we_s     = 1'b0;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    prog_len_s   = prog_len_r;
    run_start_s  = 1'b0;
    imm_valid_s  = imm_valid_r;
    imm_instr_s  = imm_instr_r;
    case (state_r)
      LOAD: begin
        if (run_press_s) begin
          if (prog_len_r != '0) begin
            run_start_s  = 1'b1;
            next_state_s = RUNNING;
          end else begin
            next_state_s = LOAD;
          end
        end else if (user_press_s && !full_r) begin
          mem_we_s    = 1'b1;
          mem_addr_s  = prog_len_r[ADDR_W-1:0];
          mem_wdata_s = sw_s;
          prog_len_s  = prog_len_r + LEN_ONE;
        end else begin
          next_state_s = LOAD;
        end
      end
      RUNNING: begin
        if (cpu_done) begin
          next_state_s = IMMEDIATE;
        end else begin
          next_state_s = RUNNING;
        end
      end
      IMMEDIATE: begin
        if (imm_valid_r) begin
          // Pending immediate blocks both buttons until the core takes it.
          if (imm_ready) begin
            imm_valid_s = 1'b0;
          end else begin
            imm_valid_s = 1'b1;
          end
        end else if (run_press_s) begin
          run_start_s  = 1'b1;
          next_state_s = RUNNING;
        end else if (user_press_s) begin
          imm_valid_s = 1'b1;
          imm_instr_s = sw_s;
        end else begin
          next_state_s = IMMEDIATE;
        end
      end
      default: begin
        next_state_s = LOAD;
      end
    endcase
  end

  // Registered outputs and program bookkeeping.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      prog_len_r  <= '0;
      full_r      <= 1'b0;
      run_start_r <= 1'b0;
      running_r   <= 1'b0;
      imm_valid_r <= 1'b0;
      imm_instr_r <= '0;
    end else begin
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      prog_len_r  <= prog_len_s;
      full_r      <= (prog_len_s == CAPACITY);
      run_start_r <= run_start_s;
      running_r   <= (next_state_s == RUNNING);
      imm_valid_r <= imm_valid_s;
      imm_instr_r <= imm_instr_s;
    end
  end

  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign prog_len  = prog_len_r;
  assign full      = full_r;
  assign run_start = run_start_r;
  assign running   = running_r;
  assign imm_valid = imm_valid_r;
  assign imm_instr = imm_instr_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard and run-pulse counter.
module tb_prog_loader;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              clr;
  logic [7:0]        sw;
  logic [1:0]        btn;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W:0]   prog_len;
  logic              full;
  logic              run_start;
  logic              running;
  logic              cpu_done;
  logic              imm_valid;
  logic [7:0]        imm_instr;
  logic              imm_ready;

  prog_loader #(.ADDR_W(ADDR_W), .DEBOUNCE_CYCLES(2)) dut (
    .clk       (clk),
    .clr       (clr),
    .sw        (sw),
    .btn       (btn),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .prog_len  (prog_len),
    .full      (full),
    .run_start (run_start),
    .running   (running),
    .cpu_done  (cpu_done),
    .imm_valid (imm_valid),
    .imm_instr (imm_instr),
    .imm_ready (imm_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int run_count = 0;
  int write_count = 0;
  logic [11:0] wr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] b, input int hold);
    btn = b;
    repeat (hold) tick();
    btn = 2'b00;
    repeat (4) tick();
  endtask

  // Scoreboard: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (run_start === 1'b1) run_count++;
    if (mem_we === 1'b1) begin
      write_count++;
      checks++;
      assert (wr_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=%0h_%0h expected=none", mem_addr, mem_wdata);
      end
      if (wr_q.size() != 0) begin
        logic [11:0] e;
        e = wr_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[11:8]));
        check("wr_data", 32'(mem_wdata), 32'(e[7:0]));
      end
    end
  end

  initial begin
    int rc;
    logic [7:0] v;
    clr = 1'b1; sw = 8'h00; btn = 2'b00; cpu_done = 1'b0; imm_ready = 1'b0;
    repeat (2) tick();
    check("rst_outputs", {mem_we, mem_addr, mem_wdata, prog_len, full, run_start, running, imm_valid, imm_instr},
          32'h0);
    clr = 1'b0;
    tick();

    // Run press on an empty program is ignored.
    rc = run_count;
    press(2'b10, 2);
    check("run_empty_count", 32'(run_count), 32'(rc));
    check("run_empty_running", 32'(running), 32'd0);

    // First entry with exact latency.
    sw = 8'h01; wr_q.push_back({4'd0, 8'h01});
    btn = 2'b01;
    tick();
    check("lat_e1", 32'(mem_we), 32'd0);
    tick();
    check("lat_e2", 32'(mem_we), 32'd0);
    btn = 2'b00;
    tick();
    check("lat_e3", 32'(mem_we), 32'd1);
    tick();
    check("we_one_cycle", 32'(mem_we), 32'd0);
    repeat (3) tick();
    check("len_1", 32'(prog_len), 32'd1);

    // One-cycle glitch produces nothing.
    sw = 8'hAA;
    press(2'b01, 1);
    check("glitch_len", 32'(prog_len), 32'd1);

    // Simultaneous presses: run wins.
    rc = run_count;
    press(2'b11, 2);
    check("both_run", 32'(run_count), 32'(rc + 1));
    check("both_running", 32'(running), 32'd1);
    check("both_len", 32'(prog_len), 32'd1);

    // Presses while running are dropped.
    sw = 8'h77;
    press(2'b01, 2);
    press(2'b10, 2);
    check("run_drop_count", 32'(run_count), 32'(rc + 1));
    check("run_still", 32'(running), 32'd1);

    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    check("done_running", 32'(running), 32'd0);

    // IMMEDIATE handshake.
    sw = 8'h40;
    press(2'b01, 2);
    check("imm_valid", 32'(imm_valid), 32'd1);
    check("imm_instr", 32'(imm_instr), 32'h40);
    repeat (5) tick();
    sw = 8'h50;
    press(2'b01, 2);
    check("imm_hold", 32'(imm_instr), 32'h40);
    check("imm_hold_valid", 32'(imm_valid), 32'd1);
    press(2'b10, 2);
    check("imm_run_drop", 32'(run_count), 32'(rc + 1));
    imm_ready = 1'b1;
    tick();
    imm_ready = 1'b0;
    check("imm_clear", 32'(imm_valid), 32'd0);

    // Re-run from IMMEDIATE.
    press(2'b10, 2);
    check("rerun_count", 32'(run_count), 32'(rc + 2));
    check("rerun_running", 32'(running), 32'd1);

    // Asynchronous clear mid-run.
    #2 clr = 1'b1;
    #1;
    check("clr_outputs", {mem_we, mem_addr, mem_wdata, prog_len, full, run_start, running, imm_valid, imm_instr},
          32'h0);
    tick();
    clr = 1'b0;
    tick();

    // Fill the program, then one more press is dropped.
    for (int i = 0; i < 16; i++) begin
      v = 8'(i * 17 + 3);
      sw = v;
      wr_q.push_back({4'(i), v});
      press(2'b01, 2);
      if (i == 14) check("full_at_15", 32'(full), 32'd0);
    end
    check("full_at_16", 32'(full), 32'd1);
    check("len_16", 32'(prog_len), 32'd16);
    sw = 8'hEE;
    press(2'b01, 2);
    check("len_after_17", 32'(prog_len), 32'd16);
    check("writes_total", 32'(write_count), 32'd17);
    check("queue_drained", 32'(wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
